// File: rtl/hazard_stall_unit.sv
// Hazard detection for the 5-stage, 8-register pipeline: tracks in-flight
// destinations and freezes the front end when forwarding cannot cover a dependence.
module hazard_stall_unit #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             hazard_en,
  output logic [REG_W-1:0] ex_op_dest,
  output logic [REG_W-1:0] mem_op_dest,
  output logic [REG_W-1:0] wb_op_dest,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } sb_entry_t;

  sb_entry_t ex_q, mem_q, wb_q;

  logic src1_live, src2_live;
  logic hit_ex, hit_mem, hit_wb;
  logic issue;

  // Destination visible to forwarding only when the stage actually writes back
  always_comb begin
    ex_op_dest  = (ex_q.valid  && ex_q.wb_en)  ? ex_q.dest  : '0;
    mem_op_dest = (mem_q.valid && mem_q.wb_en) ? mem_q.dest : '0;
    wb_op_dest  = (wb_q.valid  && wb_q.wb_en)  ? wb_q.dest  : '0;
  end

  // r0 never creates a dependence; src2 ignored for immediate forms
  always_comb begin
    src1_live = (id_src1 != '0);
    src2_live = id_src2_used && (id_src2 != '0);
    hit_ex  = (src1_live && (id_src1 == ex_op_dest))  || (src2_live && (id_src2 == ex_op_dest));
    hit_mem = (src1_live && (id_src1 == mem_op_dest)) || (src2_live && (id_src2 == mem_op_dest));
    hit_wb  = (src1_live && (id_src1 == wb_op_dest))  || (src2_live && (id_src2 == wb_op_dest));
  end

  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      if (hazard_en) stall = hit_ex || hit_mem || hit_wb;
      else           stall = hit_ex && ex_q.mem_read;
    end
    id_ex_bubble = stall || flush;
    issue        = id_valid && !stall && !flush;
  end

  // Downstream stages always advance; EX takes a bubble when ID is held or squashed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      hazard_en   <= 1'b0;
      stall_count <= '0;
    end else begin
      hazard_en <= ~frwd_en;
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      if (issue) begin
        ex_q.valid    <= 1'b1;
        ex_q.dest     <= id_dest;
        ex_q.wb_en    <= id_wb_en;
        ex_q.mem_read <= id_mem_read;
      end else begin
        ex_q <= '0;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: forwarding/no-forwarding stalls, masking, flush, reset.
module tb_hazard_stall_unit;

  localparam int unsigned REG_W = 3;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frwd_en;
  logic             id_valid;
  logic [REG_W-1:0] id_src1, id_src2, id_dest;
  logic             id_src2_used, id_wb_en, id_mem_read, flush;
  logic             hazard_en;
  logic [REG_W-1:0] ex_op_dest, mem_op_dest, wb_op_dest;
  logic             stall, id_ex_bubble;
  logic [CNT_W-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .frwd_en(frwd_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .flush(flush), .hazard_en(hazard_en), .ex_op_dest(ex_op_dest),
    .mem_op_dest(mem_op_dest), .wb_op_dest(wb_op_dest), .stall(stall),
    .id_ex_bubble(id_ex_bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction (valid, src1, src2, src2_used, dest, wb_en, mem_read, flush)
  task automatic drive(input logic v, input int s1, input int s2, input logic u,
                       input int d, input logic wb, input logic mr, input logic fl);
    id_valid     = v;
    id_src1      = REG_W'(s1);
    id_src2      = REG_W'(s2);
    id_src2_used = u;
    id_dest      = REG_W'(d);
    id_wb_en     = wb;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    frwd_en = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Reset then idle
    tick(); tick();
    check("rst_hazard_en", 32'(hazard_en), 0);
    check("rst_ex_dest", 32'(ex_op_dest), 0);
    check("rst_mem_dest", 32'(mem_op_dest), 0);
    check("rst_wb_dest", 32'(wb_op_dest), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_bubble", 32'(id_ex_bubble), 0);
    check("rst_count", 32'(stall_count), 0);
    rst_n = 1'b1;
    tick();
    check("fwd_hazard_en", 32'(hazard_en), 0);

    // Load-use with forwarding: lw r2; add r3,r2,r1
    drive(1'b1, 1, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    #1 check("lu_lw_stall", 32'(stall), 0);
    tick();
    drive(1'b1, 2, 1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    #1 check("lu_stall", 32'(stall), 1);
    check("lu_bubble", 32'(id_ex_bubble), 1);
    check("lu_ex_dest", 32'(ex_op_dest), 2);
    tick();
    #1 check("lu_released", 32'(stall), 0);
    check("lu_ex_empty", 32'(ex_op_dest), 0);
    check("lu_mem_dest", 32'(mem_op_dest), 2);
    check("lu_count", 32'(stall_count), 1);
    tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1 check("lu_add_in_ex", 32'(ex_op_dest), 3);
    check("lu_wb_dest", 32'(wb_op_dest), 2);
    idle(3);

    // ALU dependence with forwarding: add r2; sub r4,r2,r2
    drive(1'b1, 1, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2, 2, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    #1 check("alu_stall", 32'(stall), 0);
    check("alu_ex_dest", 32'(ex_op_dest), 2);
    idle(4);
    check("alu_count", 32'(stall_count), 1);

    // r0 masking: lw r0; add r1,r0,r0
    drive(1'b1, 1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    #1 check("r0_stall", 32'(stall), 0);
    check("r0_bubble", 32'(id_ex_bubble), 0);
    idle(4);

    // Immediate masking: lw r3; addi r4,r1,#imm with src2 field = 3 unused
    drive(1'b1, 1, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1, 3, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    #1 check("imm_stall", 32'(stall), 0);
    check("imm_ex_dest", 32'(ex_op_dest), 3);
    idle(4);

    // Flush over a load-use pair
    drive(1'b1, 1, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2, 1, 1'b1, 3, 1'b1, 1'b0, 1'b1);
    #1 check("fl_stall", 32'(stall), 0);
    check("fl_bubble", 32'(id_ex_bubble), 1);
    tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1 check("fl_ex_empty", 32'(ex_op_dest), 0);
    check("fl_count", 32'(stall_count), 1);
    idle(3);

    // No forwarding: add r5; or r6,r5,r1 stalls 3 cycles
    frwd_en = 1'b0;
    idle(2);
    check("nf_hazard_en", 32'(hazard_en), 1);
    drive(1'b1, 1, 1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("nf_stall%0d", i), 32'(stall), 1);
      tick();
    end
    #1 check("nf_released", 32'(stall), 0);
    check("nf_count", 32'(stall_count), 4);
    tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1 check("nf_or_in_ex", 32'(ex_op_dest), 6);
    idle(3);

    // Reset asserted during a no-forwarding stall
    drive(1'b1, 1, 1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
    #1 check("rs_stall_before", 32'(stall), 1);
    rst_n = 1'b0;
    tick();
    #1 check("rs_stall_after", 32'(stall), 0);
    check("rs_count", 32'(stall_count), 0);
    check("rs_hazard_en", 32'(hazard_en), 0);
    rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
